// File: rtl/i2c_master_ctrl.sv
// Single-register-transaction master for the one-bit-per-clk I2C slave on a shared sda net.
// Optional automatic re-attempt after a NACK: define I2C_MASTER_RETRY_EN.
module i2c_master_ctrl #(
  parameter int MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        sda,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_wdata,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       nack_err,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK1, REG, ACK2, WDATA, ACK3, GAP, RADDR, RDATA, STOP0, STOP1
  } state_e;

  localparam int RetryW = $clog2(MAX_RETRY + 1) + 1;
`ifdef I2C_MASTER_RETRY_EN
  localparam int unsigned RetryLimit = MAX_RETRY;
`else
  localparam int unsigned RetryLimit = 0;
`endif

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [6:0]        dev_q, dev_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic              nack_err_q, nack_err_d;
  logic              nack_q, nack_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              sda_oe_q, sda_oe_d;
  logic              sda_out_q, sda_out_d;
  logic              sda_low;
  logic [7:0]        obyte;

  // Anything other than a clean 0 (including a floating line) reads as 1.
  always_comb begin
    sda_low = 1'b0;
    if (sda == 1'b0) sda_low = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      rw_q       <= 1'b0;
      dev_q      <= 7'd0;
      reg_q      <= 8'd0;
      wdata_q    <= 8'd0;
      shift_q    <= 8'd0;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      nack_err_q <= 1'b0;
      nack_q     <= 1'b0;
      retry_q    <= '0;
      sda_oe_q   <= 1'b0;
      sda_out_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      shift_q    <= shift_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      nack_err_q <= nack_err_d;
      nack_q     <= nack_d;
      retry_q    <= retry_d;
      sda_oe_q   <= sda_oe_d;
      sda_out_q  <= sda_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    shift_d    = shift_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    nack_err_d = 1'b0;
    nack_d     = nack_q;
    retry_d    = retry_q;
    sda_oe_d   = 1'b0;
    sda_out_d  = 1'b1;
    obyte      = 8'h00;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rw_d    = cmd_rw;
          dev_d   = cmd_dev_addr;
          reg_d   = cmd_reg_addr;
          wdata_d = cmd_wdata;
          nack_d  = 1'b0;
          retry_d = '0;
          state_d = START;
        end
      end
      START: begin
        state_d = ADDR;
        cnt_d   = 3'd7;
      end
      ADDR: begin
        if (cnt_q == 3'd0) state_d = ACK1;
        else cnt_d = cnt_q - 3'd1;
      end
      ACK1: begin
        if (sda_low) begin
          state_d = REG;
          cnt_d   = 3'd7;
        end else begin
          state_d = STOP0;
          nack_d  = 1'b1;
        end
      end
      REG: begin
        if (cnt_q == 3'd0) state_d = ACK2;
        else cnt_d = cnt_q - 3'd1;
      end
      ACK2: begin
        if (!sda_low) begin
          state_d = STOP0;
          nack_d  = 1'b1;
        end else if (rw_q) begin
          state_d = GAP;
        end else begin
          state_d = WDATA;
          cnt_d   = 3'd7;
        end
      end
      WDATA: begin
        if (cnt_q == 3'd0) state_d = ACK3;
        else cnt_d = cnt_q - 3'd1;
      end
      GAP: begin
        state_d = RADDR;
        cnt_d   = 3'd7;
      end
      RADDR: begin
        if (cnt_q == 3'd0) state_d = ACK3;
        else cnt_d = cnt_q - 3'd1;
      end
      ACK3: begin
        if (!sda_low) begin
          state_d = STOP0;
          nack_d  = 1'b1;
        end else if (rw_q) begin
          state_d = RDATA;
          cnt_d   = 3'd7;
        end else begin
          state_d = STOP0;
        end
      end
      RDATA: begin
        shift_d = {shift_q[6:0], ~sda_low};
        if (cnt_q == 3'd0) state_d = STOP0;
        else cnt_d = cnt_q - 3'd1;
      end
      STOP0: state_d = STOP1;
      STOP1: begin
        // A failed attempt with retries left restarts the captured command from START.
        if (nack_q && (retry_q != RetryW'(RetryLimit))) begin
          retry_d = retry_q + 1'b1;
          nack_d  = 1'b0;
          state_d = START;
        end else begin
          state_d    = IDLE;
          done_d     = 1'b1;
          nack_err_d = nack_q;
          if (!nack_q && rw_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line drive is decoded from the upcoming state so it lands registered with it.
    case (state_d)
      START, STOP0: begin
        sda_oe_d  = 1'b1;
        sda_out_d = 1'b0;
      end
      STOP1: begin
        sda_oe_d  = 1'b1;
        sda_out_d = 1'b1;
      end
      ADDR: begin
        obyte     = {dev_q, 1'b0};
        sda_oe_d  = 1'b1;
        sda_out_d = obyte[cnt_d];
      end
      REG: begin
        sda_oe_d  = 1'b1;
        sda_out_d = reg_q[cnt_d];
      end
      WDATA: begin
        sda_oe_d  = 1'b1;
        sda_out_d = wdata_q[cnt_d];
      end
      RADDR: begin
        obyte     = {dev_q, 1'b1};
        sda_oe_d  = 1'b1;
        sda_out_d = obyte[cnt_d];
      end
      default: begin
        sda_oe_d  = 1'b0;
        sda_out_d = 1'b1;
      end
    endcase
  end

  assign sda       = sda_oe_q ? sda_out_q : 1'bz;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign nack_err  = nack_err_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Self-checking bench for i2c_master_ctrl: a per-cycle bus schedule is derived from the
// transaction rules and compared against sda and the handshake outputs every cycle.
module tb_i2c_master_ctrl;

  localparam int MaxRetry = 2;
`ifdef I2C_MASTER_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  wire        sda;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_dev_addr;
  logic [7:0] cmd_reg_addr;
  logic [7:0] cmd_wdata;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic       nack_err;
  logic       busy;

  // Slave side of the bus: drives only when slaveOe is set, otherwise the pull-up wins.
  logic slaveOe;
  logic slaveBit;
  assign sda = slaveOe ? slaveBit : 1'bz;
  pullup (sda);

  i2c_master_ctrl #(.MAX_RETRY(MaxRetry)) dut (
    .clk         (clk),
    .rst         (rst),
    .sda         (sda),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rw      (cmd_rw),
    .cmd_dev_addr(cmd_dev_addr),
    .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata   (cmd_wdata),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .done        (done),
    .nack_err    (nack_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic lvl;
    logic so;
    logic sv;
  } slot_t;

  slot_t      sched[$];
  logic       expNack;
  logic [7:0] lastRd;
  int         nCompared;
  int         nMismatched;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void pushSlot(input logic lvl, input logic so, input logic sv);
    slot_t s;
    s.lvl = lvl;
    s.so  = so;
    s.sv  = sv;
    sched.push_back(s);
  endfunction

  function automatic void pushByteOut(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) pushSlot(b[i], 1'b0, 1'b0);
  endfunction

  // An acknowledging slave pulls the line low; an absent one leaves it to the pull-up.
  function automatic void pushAck(input bit ack);
    if (ack) pushSlot(1'b0, 1'b1, 1'b0);
    else pushSlot(1'b1, 1'b0, 1'b0);
  endfunction

  // Expected bus levels for cycles T1.. up to the last STOP1, covering all attempts.
  function automatic void buildSchedule(input logic rw, input logic [6:0] dev, input logic [7:0] regA,
                                        input logic [7:0] wd, input logic [7:0] rd,
                                        input int nackSlot, input int nackAttempts);
    bit failed;
    int ns;
    sched.delete();
    failed = 1'b0;
    for (int a = 0; a <= MaxRetry; a++) begin
      ns = (a < nackAttempts) ? nackSlot : 0;
      failed = 1'b0;
      pushSlot(1'b0, 1'b0, 1'b0);
      pushByteOut({dev, 1'b0});
      pushAck(ns != 1);
      if (ns == 1) failed = 1'b1;
      else begin
        pushByteOut(regA);
        pushAck(ns != 2);
        if (ns == 2) failed = 1'b1;
        else if (!rw) begin
          pushByteOut(wd);
          pushAck(ns != 3);
          failed = (ns == 3);
        end else begin
          pushSlot(1'b1, 1'b0, 1'b0);
          pushByteOut({dev, 1'b1});
          pushAck(ns != 3);
          if (ns == 3) failed = 1'b1;
          else for (int i = 7; i >= 0; i--) pushSlot(rd[i], 1'b1, rd[i]);
        end
      end
      pushSlot(1'b0, 1'b0, 1'b0);
      pushSlot(1'b1, 1'b0, 1'b0);
      if (!failed || !RetryEn || a >= MaxRetry) break;
    end
    expNack = failed;
  endfunction

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checkOutput("idle_sda", 32'(sda), 32'd1);
      checkOutput("idle_status", 32'({cmd_ready, busy, done, rd_valid, nack_err}), 32'(5'b10000));
    end
  endtask

  // Called at a negedge while the master is idle; hold keeps cmd_valid high throughout.
  task automatic applyStimulus(input logic rw, input logic [6:0] dev, input logic [7:0] regA,
                               input logic [7:0] wd, input logic [7:0] rd,
                               input int nackSlot, input int nackAttempts, input bit hold);
    int n;
    logic [4:0] expStat;
    buildSchedule(rw, dev, regA, wd, rd, nackSlot, nackAttempts);
    n = sched.size() + 1;
    cmd_rw       = rw;
    cmd_dev_addr = dev;
    cmd_reg_addr = regA;
    cmd_wdata    = wd;
    cmd_valid    = 1'b1;
    checkOutput("ready_T0", 32'(cmd_ready), 32'd1);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (k == 1 && !hold) cmd_valid = 1'b0;
      if (k < n) begin
        slaveOe  = sched[k-1].so;
        slaveBit = sched[k-1].sv;
      end else begin
        slaveOe = 1'b0;
      end
      @(negedge clk);
      if (k < n) begin
        checkOutput($sformatf("sda_T%0d", k), 32'(sda), 32'(sched[k-1].lvl));
        expStat = 5'b01000;
      end else begin
        checkOutput($sformatf("sda_T%0d", k), 32'(sda), 32'd1);
        if (rw && !expNack) lastRd = rd;
        expStat = {1'b1, 1'b0, 1'b1, rw && !expNack, expNack};
        checkOutput("rd_data", 32'(rd_data), 32'(lastRd));
      end
      checkOutput($sformatf("status_T%0d", k), 32'({cmd_ready, busy, done, rd_valid, nack_err}),
                  32'(expStat));
    end
  endtask

  // Read interrupted by reset during T15-T16; reg bits on T16/T17 are zero so a line
  // still being driven would read low.
  task automatic resetMidRead();
    logic [6:0] dev;
    logic [7:0] regA;
    dev  = 7'($urandom);
    regA = 8'($urandom) & 8'hF9;
    buildSchedule(1'b1, dev, regA, 8'h00, 8'h00, 0, 0);
    cmd_rw       = 1'b1;
    cmd_dev_addr = dev;
    cmd_reg_addr = regA;
    cmd_wdata    = 8'h00;
    cmd_valid    = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) cmd_valid = 1'b0;
      if (k == 15) rst = 1'b1;
      slaveOe  = sched[k-1].so;
      slaveBit = sched[k-1].sv;
      @(negedge clk);
      checkOutput($sformatf("rstrd_sda_T%0d", k), 32'(sda), 32'(sched[k-1].lvl));
    end
    @(posedge clk);
    #1;
    slaveOe = 1'b0;
    @(negedge clk);
    checkOutput("rstrd_sda_T16", 32'(sda), 32'd1);
    checkOutput("rstrd_pulses_T16", 32'({done, rd_valid, nack_err}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    lastRd = 8'h00;
    checkOutput("rstrd_rd_data", 32'(rd_data), 32'h00);
    idleCycles(4);
  endtask

  initial begin
    logic       rw;
    logic       hold;
    int         ns;
    int         na;
    nCompared    = 0;
    nMismatched  = 0;
    lastRd       = 8'h00;
    rst          = 1'b1;
    slaveOe      = 1'b0;
    slaveBit     = 1'b1;
    cmd_valid    = 1'b0;
    cmd_rw       = 1'b0;
    cmd_dev_addr = 7'h00;
    cmd_reg_addr = 8'h00;
    cmd_wdata    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_status", 32'({cmd_ready, busy, done, rd_valid, nack_err}), 32'(5'b10000));
    checkOutput("reset_rd_data", 32'(rd_data), 32'h00);
    checkOutput("reset_sda", 32'(sda), 32'd1);

    $display("[TB] directed transactions");
    applyStimulus(1'b0, 7'h2A, 8'h5E, 8'hA5, 8'h00, 0, 0, 1'b0);
    idleCycles(2);
    applyStimulus(1'b1, 7'h2A, 8'h7C, 8'h00, 8'h96, 0, 0, 1'b0);
    idleCycles(2);
    applyStimulus(1'b1, 7'h13, 8'h20, 8'h00, 8'h55, 1, 3, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 7'h11, 8'h22, 8'h33, 8'h00, 0, 0, 1'b1);
    applyStimulus(1'b0, 7'h44, 8'h55, 8'h66, 8'h00, 0, 0, 1'b0);
    idleCycles(2);
    resetMidRead();
    if (RetryEn) begin
      applyStimulus(1'b0, 7'h2A, 8'h5E, 8'hA5, 8'h00, 1, MaxRetry, 1'b0);
      idleCycles(1);
    end

    $display("[TB] randomized transactions");
    for (int t = 0; t < 30; t++) begin
      rw   = 1'($urandom);
      hold = (t != 29) && ($urandom_range(0, 3) == 0);
      ns   = $urandom_range(1, 3);
      na   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      applyStimulus(rw, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), ns, na, hold);
      if (!hold) idleCycles($urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
